sixteen_bit_countdown_timer: RTL and testbench

Loadable 16-bit countdown timer with programmable prescaler, one-shot or auto-reload operation, and a one-cycle expiry pulse. It is the sequential stage directly downstream of the gate-level decrementer: it registers the count, feeds the count to `sixteenBitDecrementer` each tick, and captures the result. It serves as a general-purpose event or delay timer for the lab datapath.

---
 rtl/sixteen_bit_countdown_timer_pkg.sv | 11 +
 rtl/sixteen_bit_countdown_timer_decrementer.sv | 11 +
 rtl/sixteen_bit_countdown_timer.sv | 103 ++++++++++
 tb/tb_sixteen_bit_countdown_timer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sixteen_bit_countdown_timer_pkg.sv
// Shared constants and state encoding for the 16-bit countdown timer and its decrementer.
package sixteen_bit_countdown_timer_pkg;

    localparam int unsigned COUNT_W = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/sixteen_bit_countdown_timer_decrementer.sv
// Combinational decrement-by-one; result bit COUNT_W is the borrow, set only for an input of 0.
module sixteenBitDecrementer
    import sixteen_bit_countdown_timer_pkg::*;
(
    input  logic [COUNT_W-1:0] a,
    output logic [COUNT_W:0]   result
);

    assign result = {1'b0, a} - {{COUNT_W{1'b0}}, 1'b1};

endmodule

// File: rtl/sixteen_bit_countdown_timer.sv
// Loadable countdown timer with prescaler, one-shot or auto-reload mode and a one-cycle expiry pulse.
module sixteen_bit_countdown_timer
    import sixteen_bit_countdown_timer_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [COUNT_W-1:0]    load_value,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  auto_reload,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [COUNT_W-1:0]    count,
    output logic                  busy,
    output logic                  done,
    output logic                  zero
);

    state_e                  state_q, state_d;
    logic [COUNT_W-1:0]      count_q, count_d;
    logic [COUNT_W-1:0]      reload_q, reload_d;
    logic [PRESCALE_W-1:0]   pc_q, pc_d;
    logic                    done_q, done_d;
    logic [COUNT_W:0]        decResult;
    logic                    tickNow;

    sixteenBitDecrementer uDec (
        .a      (count_q),
        .result (decResult)
    );

    assign tickNow = (state_q == ST_RUN) && (pc_q == prescale);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            pc_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            pc_q     <= pc_d;
            done_q   <= done_d;
        end
    end

    // Priority: load > stop > start > tick.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        pc_d     = pc_q;
        done_d   = 1'b0;
        if (load) begin
            count_d  = load_value;
            reload_d = load_value;
            pc_d     = '0;
            state_d  = ST_IDLE;
        end else if (stop) begin
            if (state_q == ST_RUN) begin
                state_d = ST_IDLE;
                pc_d    = '0;
            end
        end else if (state_q == ST_IDLE) begin
            if (start && (count_q != '0)) begin
                state_d = ST_RUN;
                pc_d    = '0;
            end
        end else if (tickNow) begin
            pc_d = '0;
            if (count_q > {{(COUNT_W-1){1'b0}}, 1'b1}) begin
                count_d = decResult[COUNT_W-1:0];
            end else begin
                done_d = 1'b1;
                if (auto_reload && (reload_q != '0)) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = ST_IDLE;
                end
            end
        end else begin
            pc_d = pc_q + {{(PRESCALE_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        count = count_q;
        busy  = (state_q == ST_RUN);
        done  = done_q;
        zero  = (count_q == '0);
    end

    // RUN is never entered with a zero count, so a tick must never borrow.
    zeroGuard: assert property (@(posedge clk) disable iff (!rst_n)
        tickNow |-> !decResult[COUNT_W]);

endmodule

// File: tb/tb_sixteen_bit_countdown_timer.sv
// Directed self-checking bench for the countdown timer: reset, one-shot, prescale, reload, stop.
module tb_sixteen_bit_countdown_timer;

    localparam int unsigned PW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   load_value = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          auto_reload = 1'b0;
    logic [PW-1:0] prescale = '0;
    logic [15:0]   count;
    logic          busy;
    logic          done;
    logic          zero;

    int nCmp = 0;
    int nBad = 0;

    sixteen_bit_countdown_timer #(
        .PRESCALE_W (PW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .load_value  (load_value),
        .start       (start),
        .stop        (stop),
        .auto_reload (auto_reload),
        .prescale    (prescale),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .zero        (zero)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doLoad(input logic [15:0] v, input logic [PW-1:0] p);
        load_value = v;
        prescale   = p;
        load       = 1'b1;
        step();
        load       = 1'b0;
    endtask

    // Returns just after edge E0 where start was sampled.
    task automatic doStart();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        nCmp++;
        if ({count, busy, done, zero} !== {16'h0000, 1'b0, 1'b0, 1'b1}) begin
            nBad++;
            $display("FAIL reset_init: got cnt=%h busy=%b done=%b zero=%b, want 0000 0 0 1",
                     count, busy, done, zero);
        end
        rst_n = 1'b1;
        step();
        doLoad(16'h0005, '0);
        doStart();
        step();
        step();
        nCmp++;
        if ({count, busy} !== {16'h0003, 1'b1}) begin
            nBad++;
            $display("FAIL reset_prerun: got cnt=%h busy=%b, want 0003 1", count, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        nCmp++;
        if ({count, busy, done, zero} !== {16'h0000, 1'b0, 1'b0, 1'b1}) begin
            nBad++;
            $display("FAIL reset_async: got cnt=%h busy=%b done=%b zero=%b, want 0000 0 0 1",
                     count, busy, done, zero);
        end
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            nCmp++;
            if ({count, busy, done} !== {16'h0000, 1'b0, 1'b0}) begin
                nBad++;
                $display("FAIL reset_release[%0d]: got cnt=%h busy=%b done=%b, want 0000 0 0",
                         k, count, busy, done);
            end
        end
    endtask

    task automatic test_one_shot();
        logic [15:0] expCount;
        doLoad(16'h0003, '0);
        doStart();
        nCmp++;
        if ({count, busy, done} !== {16'h0003, 1'b1, 1'b0}) begin
            nBad++;
            $display("FAIL oneshot_e0: got cnt=%h busy=%b done=%b, want 0003 1 0",
                     count, busy, done);
        end
        for (int k = 1; k <= 4; k++) begin
            step();
            expCount = (k >= 3) ? 16'h0000 : 16'(3 - k);
            nCmp++;
            if ({count, done, busy} !== {expCount, k == 3, k < 3}) begin
                nBad++;
                $display("FAIL oneshot[%0d]: got cnt=%h done=%b busy=%b, want %h %b %b",
                         k, count, done, busy, expCount, k == 3, k < 3);
            end
        end
    endtask

    task automatic test_prescale();
        logic [15:0] expCount;
        doLoad(16'h0002, 4'd3);
        doStart();
        for (int k = 1; k <= 9; k++) begin
            step();
            expCount = (k < 4) ? 16'h0002 : ((k < 8) ? 16'h0001 : 16'h0000);
            nCmp++;
            if ({count, done, busy} !== {expCount, k == 8, k < 8}) begin
                nBad++;
                $display("FAIL prescale[%0d]: got cnt=%h done=%b busy=%b, want %h %b %b",
                         k, count, done, busy, expCount, k == 8, k < 8);
            end
        end
    endtask

    task automatic test_auto_reload();
        logic [15:0] expCount;
        auto_reload = 1'b1;
        doLoad(16'h0002, '0);
        doStart();
        for (int k = 1; k <= 6; k++) begin
            step();
            expCount = (k % 2 == 1) ? 16'h0001 : 16'h0002;
            nCmp++;
            if ({count, done, busy, zero} !== {expCount, k % 2 == 0, 1'b1, 1'b0}) begin
                nBad++;
                $display("FAIL reload[%0d]: got cnt=%h done=%b busy=%b zero=%b, want %h %b 1 0",
                         k, count, done, busy, zero, expCount, k % 2 == 0);
            end
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        auto_reload = 1'b0;
        nCmp++;
        if (busy !== 1'b0) begin
            nBad++;
            $display("FAIL reload_stop: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_stop_resume();
        doLoad(16'h0010, '0);
        doStart();
        repeat (4) step();
        nCmp++;
        if ({count, busy} !== {16'h000C, 1'b1}) begin
            nBad++;
            $display("FAIL stop_pre: got cnt=%h busy=%b, want 000c 1", count, busy);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        repeat (2) step();
        nCmp++;
        if ({count, busy} !== {16'h000C, 1'b0}) begin
            nBad++;
            $display("FAIL stop_hold: got cnt=%h busy=%b, want 000c 0", count, busy);
        end
        doStart();
        nCmp++;
        if ({count, busy} !== {16'h000C, 1'b1}) begin
            nBad++;
            $display("FAIL resume_e0: got cnt=%h busy=%b, want 000c 1", count, busy);
        end
        step();
        nCmp++;
        if (count !== 16'h000B) begin
            nBad++;
            $display("FAIL resume_tick: got cnt=%h, want 000b", count);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_boundaries();
        int earlyDone;
        doLoad(16'h0000, '0);
        doStart();
        step();
        nCmp++;
        if ({count, busy, done, zero} !== {16'h0000, 1'b0, 1'b0, 1'b1}) begin
            nBad++;
            $display("FAIL start_zero: got cnt=%h busy=%b done=%b zero=%b, want 0000 0 0 1",
                     count, busy, done, zero);
        end

        doLoad(16'hFFFF, '0);
        doStart();
        earlyDone = 0;
        for (int i = 1; i <= 65534; i++) begin
            step();
            if (done !== 1'b0) earlyDone++;
        end
        nCmp++;
        if ({earlyDone, count} !== {32'd0, 16'h0001}) begin
            nBad++;
            $display("FAIL ffff_pre: got early_done=%0d cnt=%h, want 0 0001", earlyDone, count);
        end
        step();
        nCmp++;
        if ({count, done, busy} !== {16'h0000, 1'b1, 1'b0}) begin
            nBad++;
            $display("FAIL ffff_done: got cnt=%h done=%b busy=%b, want 0000 1 0",
                     count, done, busy);
        end

        doLoad(16'h0002, '0);
        doStart();
        step();
        load_value = 16'h0007;
        load       = 1'b1;
        step();
        load       = 1'b0;
        nCmp++;
        if ({count, done, busy} !== {16'h0007, 1'b0, 1'b0}) begin
            nBad++;
            $display("FAIL load_vs_terminal: got cnt=%h done=%b busy=%b, want 0007 0 0",
                     count, done, busy);
        end
        step();
        nCmp++;
        if ({count, done} !== {16'h0007, 1'b0}) begin
            nBad++;
            $display("FAIL load_vs_terminal_after: got cnt=%h done=%b, want 0007 0", count, done);
        end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_prescale();
        test_auto_reload();
        test_stop_resume();
        test_boundaries();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
